// File: rtl/win_pkg.sv
// Shared widths and defaults for the windowed multiplier arbiter slice.
package win_pkg;

  localparam int DATA_W      = 8;
  localparam int PROD_W      = 16;
  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W_DEF    = 2;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [PROD_W-1:0] prod_t;

  // Full-width unsigned product; both operands are widened first so nothing is truncated.
  function automatic prod_t mul_full(input data_t a, input data_t b);
    return PROD_W'(a) * PROD_W'(b);
  endfunction

endpackage

// File: rtl/win_mul_8.sv
// Combinational 8x8 unsigned multiplier shared by all requesters.
module win_mul_8
  import win_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  assign p = mul_full(a, b);

endmodule

// File: rtl/win_mul_arb.sv
// Round-robin arbiter feeding one shared multiplier through a two-stage
// (operand, result) pipeline with valid/ready handshakes on both sides.
module win_mul_arb
  import win_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = ID_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [PROD_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);

  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_RST  = ID_W'(NUM_REQ - 1);

  logic [DATA_W-1:0] op_a [NUM_REQ];
  logic [DATA_W-1:0] op_b [NUM_REQ];

  logic              s1_v_reg;
  logic [DATA_W-1:0] s1_a_reg;
  logic [DATA_W-1:0] s1_b_reg;
  logic [ID_W-1:0]   s1_id_reg;

  logic              rsp_valid_reg;
  logic [PROD_W-1:0] rsp_data_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic [ID_W-1:0]   last_grant_reg;

  logic [ID_W:0]     rr_idx;
  logic [ID_W-1:0]   win_id;
  logic              win_found;
  logic [NUM_REQ-1:0] win_onehot;

  logic              s2_adv;
  logic              s1_adv;
  logic              s1_can;
  logic              hs;
  logic [PROD_W-1:0] prod;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign op_a[gi]       = req_a[gi*DATA_W +: DATA_W];
      assign op_b[gi]       = req_b[gi*DATA_W +: DATA_W];
      assign win_onehot[gi] = win_found && (win_id == ID_W'(gi));
    end
  endgenerate

  // Scan from the requester after the last winner, wrapping, and keep the first valid hit.
  always_comb begin
    rr_idx    = '0;
    win_id    = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = {1'b0, last_grant_reg} + (ID_W+1)'(k);
      if (rr_idx >= NUM_REQ_W) rr_idx = rr_idx - NUM_REQ_W;
      if (!win_found && req_valid[rr_idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = rr_idx[ID_W-1:0];
      end
    end
  end

  assign s2_adv = !rsp_valid_reg || rsp_ready;
  assign s1_adv = s1_v_reg && s2_adv;
  assign s1_can = !s1_v_reg || s1_adv;

  // Gating by rst_n keeps requesters from seeing an accept while state is held in reset.
  assign req_ready = (rst_n && s1_can) ? win_onehot : '0;
  assign hs        = |req_ready;

  win_mul_8 u_mul (
    .a (s1_a_reg),
    .b (s1_b_reg),
    .p (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_reg  <= 1'b0;
      s1_a_reg  <= '0;
      s1_b_reg  <= '0;
      s1_id_reg <= '0;
    end else if (s1_can) begin
      s1_v_reg <= hs;
      if (hs) begin
        s1_a_reg  <= op_a[win_id];
        s1_b_reg  <= op_b[win_id];
        s1_id_reg <= win_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
    end else if (s2_adv) begin
      rsp_valid_reg <= s1_v_reg;
      if (s1_adv) begin
        rsp_data_reg <= prod;
        rsp_id_reg   <= s1_id_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= LAST_RST;
    end else if (hs) begin
      last_grant_reg <= win_id;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;
  assign busy      = s1_v_reg || rsp_valid_reg;

endmodule

// File: tb/tb_win_mul_arb.sv
// Directed bench for win_mul_arb: hand-computed grants, products and ids.
module tb_win_mul_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  win_mul_arb #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, got timeout want summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) begin
      $display("chk %-18s obs=0x%0h", tag, obs);
    end else begin
      n_err++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input int id, input logic [15:0] d);
    chk({tag, "_v"},  32'(rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(rsp_id),    32'(id));
    chk({tag, "_d"},  32'(rsp_data),  32'(d));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    req_valid = '0;
    step();
    rst_n = 1'b1;
  endtask

  // One isolated transaction: accept, one cycle in S1, one cycle presented, then drained.
  task automatic send_one(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] p, input string tag);
    set_op(i, a, b);
    req_valid = 4'(1 << i);
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(1 << i));
    step();
    req_valid = '0;
    chk({tag, "_lat1"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    step();
    chk_rsp(tag, i, p);
    step();
    chk({tag, "_drain"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_idle"},  32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0001;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state; a pending request must not see ready.
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    req_valid = '0;
    rst_n     = 1'b1;

    send_one(0, 8'h12, 8'h34, 16'h03A8, "single");

    // All four held valid: grants 0,1,2,3,0 and one response per cycle.
    reset_dut();
    for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'h10);
    req_valid = 4'hF;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("rr_ready%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
      if (c < 2) chk($sformatf("rr_empty%0d", c), 32'(rsp_valid), 32'd0);
      else chk_rsp($sformatf("rr_rsp%0d", c), c - 2, 16'((c - 1) * 16));
      step();
    end
    req_valid = '0;
    chk_rsp("rr_tail3", 3, 16'h0040);
    step();
    chk_rsp("rr_wrap0", 0, 16'h0010);
    step();
    chk("rr_done", 32'(rsp_valid), 32'd0);

    // Backpressure: both stages fill, ready drops, response held stable.
    set_op(1, 8'h03, 8'h05);
    set_op(2, 8'h07, 8'h09);
    set_op(3, 8'h11, 8'h11);
    req_valid = 4'b1110;
    rsp_ready = 1'b0;
    #1;
    chk("bp_ready0", 32'(req_ready), 32'b0010);
    step();
    chk("bp_ready1", 32'(req_ready), 32'b0100);
    chk("bp_s2empty", 32'(rsp_valid), 32'd0);
    req_valid[1] = 1'b0;
    step();
    req_valid[2] = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      chk_rsp($sformatf("bp_hold%0d", c), 1, 16'h000F);
      chk($sformatf("bp_noready%0d", c), 32'(req_ready), 32'd0);
      chk($sformatf("bp_busy%0d", c), 32'(busy), 32'd1);
      if (c < 5) step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    chk_rsp("bp_out2", 2, 16'h003F);
    step();
    chk_rsp("bp_out3", 3, 16'h0121);
    step();
    chk("bp_done", 32'(rsp_valid), 32'd0);
    chk("bp_idle", 32'(busy), 32'd0);

    send_one(0, 8'h00, 8'hFF, 16'h0000, "edge_zero");
    send_one(1, 8'hFF, 8'hFF, 16'hFE01, "edge_max");
    send_one(2, 8'h80, 8'h02, 16'h0100, "edge_pow2");

    // Reset with both stages occupied.
    set_op(2, 8'h0A, 8'h0B);
    set_op(3, 8'h0C, 8'h0D);
    rsp_ready = 1'b0;
    req_valid = 4'b1100;
    #1;
    chk("mid_ready0", 32'(req_ready), 32'b1000);
    step();
    req_valid = 4'b0100;
    chk("mid_ready1", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    chk_rsp("mid_full", 3, 16'h009C);
    chk("mid_busy", 32'(busy), 32'd1);
    set_op(0, 8'h05, 8'h06);
    req_valid = 4'hF;
    rst_n     = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    step();
    chk("mid_rst_hold", 32'(rsp_valid), 32'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("mid_first_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    chk("mid_no_stale", 32'(rsp_valid), 32'd0);
    step();
    chk_rsp("mid_out0", 0, 16'h001E);
    step();
    chk("mid_done", 32'(rsp_valid), 32'd0);

    // Fairness: req2 alone, then 1 and 3 join -> 3, 1, 2.
    set_op(1, 8'h02, 8'h03);
    set_op(2, 8'h04, 8'h05);
    set_op(3, 8'h06, 8'h07);
    req_valid = 4'b0100;
    #1;
    chk("fair_g2", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b1110;
    #1;
    chk("fair_g3", 32'(req_ready), 32'b1000);
    step();
    chk("fair_g1", 32'(req_ready), 32'b0010);
    chk_rsp("fair_out2a", 2, 16'h0014);
    step();
    chk("fair_g2b", 32'(req_ready), 32'b0100);
    chk_rsp("fair_out3", 3, 16'h002A);
    step();
    req_valid = '0;
    chk_rsp("fair_out1", 1, 16'h0006);
    step();
    chk_rsp("fair_out2b", 2, 16'h0014);
    step();
    chk("fair_done", 32'(rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/win_mul_arb.md
WIN_MUL_ARB -- requirements
Module: win_mul_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one multiplier (legal values 2..8).
REQ-002 SHALL have parameter ID_W, default 2, requester-ID width, equal to clog2(NUM_REQ).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester operand-pair valid.
REQ-006 SHALL have port req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 SHALL have port req_a  input  NUM_REQ*8  operand A; requester i uses bits [8i+7:8i], unsigned.
REQ-008 SHALL have port req_b  input  NUM_REQ*8  operand B; same packing, unsigned.
REQ-009 SHALL have port rsp_valid  output  1  product valid.
REQ-010 SHALL have port rsp_ready  input  1  downstream accept.
REQ-011 SHALL have port rsp_data  output  16  unsigned product A*B.
REQ-012 SHALL have port rsp_id  output  ID_W  index of the requester that owns rsp_data.
REQ-013 SHALL have port busy  output  1  high while either pipeline stage holds valid data.

Function
REQ-014 SHALL use a two-stage pipeline: S1 operand register (s1_v, a, b, id) and S2 result register (rsp_valid, rsp_data, rsp_id).
REQ-015 SHALL form a handshake when req_valid[i] and req_ready[i] are both high on a rising edge; S1 then loads that requester's a, b and i.
REQ-016 SHALL compute the product combinationally from S1 through one multiplier instance and load it into S2 when S1 advances.
REQ-017 SHALL advance S2 when rsp_valid=0 or rsp_ready=1.
REQ-018 SHALL advance S1 into S2 when s1_v=1 and S2 advances; S1 can accept new operands when s1_v=0 or S1 advances.
REQ-019 SHALL assert req_ready only for the round-robin winner among the requesters with valid high, and only when S1 can accept.
REQ-020 SHALL start the round-robin search at (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 has first priority.
REQ-021 SHALL update last_grant only on a completed handshake.
REQ-022 SHALL have a latency of 2 cycles: with rsp_ready high, a handshake at edge N gives rsp_valid high after edge N+1.
REQ-023 SHALL sustain a throughput of one product per cycle when rsp_ready is held high.
REQ-024 SHALL hold rsp_valid, rsp_data and rsp_id stable while rsp_valid=1 and rsp_ready=0.
REQ-025 SHALL produce rsp_data = 0 when either operand is 0, and 0xFE01 for 0xFF*0xFF, with no truncation.
REQ-026 SHALL let req_ready depend on req_valid, S1/S2 occupancy and rsp_ready only; requesters must hold valid and operands stable until accepted.
REQ-027 SHALL refill S1 in the same cycle it drains (simultaneous drain and accept), with no bubble.
REQ-028 SHALL drive busy = s1_v OR rsp_valid.

Reset
REQ-029 SHALL clear s1_v, rsp_valid and busy to 0 while rst_n is low, independent of clk.
REQ-030 SHALL reset rsp_data to 0x0000, rsp_id to 0, last_grant to NUM_REQ-1, and S1 data to 0.
REQ-031 SHALL force req_ready to all-zero while rst_n is low; in-flight products are discarded when reset asserts mid-operation.
REQ-032 SHALL first grant on the first rising edge after rst_n deasserts.

Structure
REQ-033 SHALL take DATA_W=8 and PROD_W=16 from shared package win_pkg; NUM_REQ and ID_W defaults also live there.
REQ-034 SHALL instantiate exactly one win_mul_8 as the only sub-module; the arbiter is local logic.

Verification
REQ-035 SHALL cover single request: req0 a=0x12, b=0x34, rsp_ready=1 -> rsp_valid two edges after accept, rsp_data=0x03A8, rsp_id=0.
REQ-036 SHALL cover all four requesters held valid with rsp_ready=1 -> grants in order 0,1,2,3,0, and one rsp per cycle after fill.
REQ-037 SHALL cover backpressure: rsp_ready=0 for 5 cycles with 3 requests pending -> S1 and S2 fill, req_ready all 0, rsp held stable, no loss or reorder once released.
REQ-038 SHALL cover edge operands: (0x00,0xFF) -> 0x0000; (0xFF,0xFF) -> 0xFE01; (0x80,0x02) -> 0x0100.
REQ-039 SHALL cover reset mid-operation: rst_n low with S1 and S2 full -> rsp_valid and busy 0 immediately, and the first grant after release goes to requester 0.
REQ-040 SHALL cover fairness: only req2 valid, then req1 and req3 also valid -> next grant goes to 3, then 1, then 2.
